rv_encoder: RTL and testbench

// - Inverse of the RV32I instruction decoder: takes decoded fields (opcode, funct3, funct7, funct5, rd, rs1, rs2, imm)
//   and re-assembles the 32-bit instruction word. Sits between the test-program generator or assembler front end and
//   the instruction memory writer.
// - Encoded words are buffered in an in-order FIFO with valid/ready on both sides.

---
 rtl/rv_pkg.sv | 33 +++
 rtl/rv_sync_fifo.sv | 50 +++++
 rtl/rv_encoder.sv | 103 ++++++++++
 tb/tb_rv_encoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcode constants, instruction format enum and opcode-to-format lookup
package rv_pkg;

    localparam logic [4:0] OP       = 5'b01100;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] LOAD     = 5'b00000;
    localparam logic [4:0] MISC_MEM = 5'b00011;
    localparam logic [4:0] JALR     = 5'b11001;
    localparam logic [4:0] STORE    = 5'b01000;
    localparam logic [4:0] BRANCH   = 5'b11000;
    localparam logic [4:0] AUIPC    = 5'b00101;
    localparam logic [4:0] LUI      = 5'b01101;
    localparam logic [4:0] JAL      = 5'b11011;
    localparam logic [4:0] SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_ILLEGAL
    } fmt_t;

    function automatic fmt_t opcode_to_fmt(input logic [4:0] op);
        case (op)
            OP:                             return FMT_R;
            OP_IMM, LOAD, MISC_MEM, JALR:   return FMT_I;
            STORE:                          return FMT_S;
            BRANCH:                         return FMT_B;
            AUIPC, LUI:                     return FMT_U;
            JAL:                            return FMT_J;
            SYSTEM:                         return FMT_SYS;
            default:                        return FMT_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// rv_sync_fifo: in-order FIFO with occupancy count; head data reads as zero while empty
module rv_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = empty ? '0 : mem[rptr];

    // pointers wrap naturally modulo DEPTH; count tracks simultaneous push/pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_en);
            rptr  <= rptr + AW'(rd_en);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // storage needs no reset: empty masks stale entries on the read side
    always_ff @(posedge clock) begin
        if (wr_en) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/rv_encoder.sv
// rv_encoder: rebuilds RV32I instruction words from decoded fields into an output FIFO.
// Define RV_ENCODER_IMM_CHECK_EN to flag immediates that the format cannot represent exactly.
module rv_encoder
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [4:0]                      in_opcode,
    input  logic [2:0]                      in_funct3,
    input  logic [6:0]                      in_funct7,
    input  logic [4:0]                      in_funct5,
    input  logic [4:0]                      in_rd,
    input  logic [4:0]                      in_rs1,
    input  logic [4:0]                      in_rs2,
    input  logic [31:0]                     in_imm,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_inst,
    output logic                            out_sigill,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] out_count
);

    fmt_t        fmt;
    logic [31:0] inst;
    logic        ill;
    logic        ok_is;
    logic        ok_b;
    logic        ok_u;
    logic        ok_j;
    logic        full;
    logic        empty;
    logic [32:0] head;

`ifdef RV_ENCODER_IMM_CHECK_EN
    assign ok_is = in_imm == {{20{in_imm[11]}}, in_imm[11:0]};
    assign ok_b  = in_imm == {{19{in_imm[12]}}, in_imm[12:1], 1'b0};
    assign ok_j  = in_imm == {{11{in_imm[20]}}, in_imm[20:1], 1'b0};
    assign ok_u  = in_imm[11:0] == '0;
`else
    assign ok_is = 1'b1;
    assign ok_b  = 1'b1;
    assign ok_j  = 1'b1;
    assign ok_u  = 1'b1;
`endif

    assign fmt = opcode_to_fmt(in_opcode);

    // place fields per format; an unencodable entry is queued as all-zero with sigill set
    always_comb begin
        inst = '0;
        ill  = 1'b0;
        unique case (fmt)
            FMT_R: inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
            FMT_I: begin
                inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
                ill  = ~ok_is;
            end
            FMT_S: begin
                inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode, 2'b11};
                ill  = ~ok_is;
            end
            FMT_B: begin
                inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode, 2'b11};
                ill  = ~ok_b;
            end
            FMT_U: begin
                inst = {in_imm[31:12], in_rd, in_opcode, 2'b11};
                ill  = ~ok_u;
            end
            FMT_J: begin
                inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode, 2'b11};
                ill  = ~ok_j;
            end
            FMT_SYS: begin
                inst = {in_funct7, in_funct5, 5'b0, 3'b000, 5'b0, in_opcode, 2'b11};
                ill  = in_funct3 != 3'b000;
            end
            FMT_ILLEGAL: ill = 1'b1;
        endcase
    end

    rv_sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (in_valid),
        .wdata   ({ill, ill ? 32'h0 : inst}),
        .pop     (out_ready),
        .rdata   (head),
        .count   (out_count),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready   = ~full;
    assign out_valid  = ~empty;
    assign out_sigill = head[32];
    assign out_inst   = head[31:0];

endmodule

// File: tb/tb_rv_encoder.sv
// tb_rv_encoder: directed checks of encoding, FIFO ordering, backpressure and reset
module tb_rv_encoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_funct5 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_sigill;
    logic [2:0]  out_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  f5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] ei;
        logic        es;
    } vec_t;

    rv_encoder #(.FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_funct5  (in_funct5),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_sigill (out_sigill),
        .out_count  (out_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fields(input vec_t v);
        in_opcode = v.op;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_funct5 = v.f5;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
    endtask

    function automatic vec_t addi_vec(input int i);
        vec_t v;
        v = '{5'b00100, 3'd0, 7'd0, 5'd0, 5'(i), 5'd0, 5'd0, 32'(i), 32'h0, 1'b0};
        v.ei = {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", out_count); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", out_inst); end
        total++; if (out_sigill !== 1'b0) begin bad++; $display("FAIL reset_sigill got=%b want=0", out_sigill); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_encode();
        vec_t v [12];
        v[0]  = '{5'b00100, 3'd0, 7'd0,    5'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0};
        v[1]  = '{5'b01101, 3'd0, 7'd0,    5'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        v[2]  = '{5'b11000, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        v[3]  = '{5'b11011, 3'd0, 7'd0,    5'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0};
        v[4]  = '{5'b11100, 3'd0, 7'd0,    5'd1, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0010_0073, 1'b0};
        v[5]  = '{5'b11111, 3'd0, 7'd0,    5'd0, 5'd3, 5'd4, 5'd5, 32'h1234,      32'h0,         1'b1};
        v[6]  = '{5'b01100, 3'd0, 7'd0,    5'd0, 5'd3, 5'd1, 5'd2, 32'h0,         32'h0020_81B3, 1'b0};
        v[7]  = '{5'b01100, 3'd0, 7'h20,   5'd0, 5'd3, 5'd1, 5'd2, 32'h0,         32'h4020_81B3, 1'b0};
        v[8]  = '{5'b01000, 3'd2, 7'd0,    5'd0, 5'd0, 5'd1, 5'd2, 32'h8,         32'h0020_A423, 1'b0};
        v[9]  = '{5'b11100, 3'd1, 7'd0,    5'd0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         1'b1};
        v[10] = '{5'b11100, 3'd0, 7'd0,    5'd0, 5'd5, 5'd7, 5'd9, 32'h0,         32'h0000_0073, 1'b0};
`ifdef RV_ENCODER_IMM_CHECK_EN
        v[11] = '{5'b00100, 3'd0, 7'd0,    5'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0800, 32'h0,         1'b1};
`else
        v[11] = '{5'b00100, 3'd0, 7'd0,    5'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0800, 32'h8001_0093, 1'b0};
`endif
        for (int i = 0; i < 12; i++) begin
            set_fields(v[i]);
            in_valid = 1'b1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL enc%0d_pre_valid got=%b want=0", i, out_valid); end
            step();
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL enc%0d_valid got=%b want=1", i, out_valid); end
            total++; if (out_inst !== v[i].ei) begin bad++; $display("FAIL enc%0d_inst got=%h want=%h", i, out_inst, v[i].ei); end
            total++; if (out_sigill !== v[i].es) begin bad++; $display("FAIL enc%0d_sigill got=%b want=%b", i, out_sigill, v[i].es); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            total++; if (out_count !== 3'd0) begin bad++; $display("FAIL enc%0d_drain got=%0d want=0", i, out_count); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic       exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vec_t       e;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            set_fields(addi_vec(i));
            step();
            total++; if (out_count !== exp_cnt[i-1]) begin bad++; $display("FAIL bp_count%0d got=%0d want=%0d", i, out_count, exp_cnt[i-1]); end
            total++; if (in_ready !== exp_rdy[i-1]) begin bad++; $display("FAIL bp_ready%0d got=%b want=%b", i, in_ready, exp_rdy[i-1]); end
        end
        e = addi_vec(1);
        total++; if (out_inst !== e.ei) begin bad++; $display("FAIL bp_hold got=%h want=%h", out_inst, e.ei); end
        step();
        total++; if (out_inst !== e.ei) begin bad++; $display("FAIL bp_stable got=%h want=%h", out_inst, e.ei); end
        out_ready = 1'b1;
        step();
        total++; if (out_count !== 3'd3) begin bad++; $display("FAIL bp_pop_only got=%0d want=3", out_count); end
        e = addi_vec(2);
        total++; if (out_inst !== e.ei) begin bad++; $display("FAIL bp_order2 got=%h want=%h", out_inst, e.ei); end
        step();
        in_valid = 1'b0;
        total++; if (out_count !== 3'd3) begin bad++; $display("FAIL bp_push_pop got=%0d want=3", out_count); end
        for (int i = 3; i <= 5; i++) begin
            e = addi_vec(i);
            total++; if (out_inst !== e.ei) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", i, out_inst, e.ei); end
            step();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        vec_t e;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_fields(addi_vec(i + 8));
            step();
        end
        total++; if (out_count !== 3'd3) begin bad++; $display("FAIL rst_fill got=%0d want=3", out_count); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", out_count); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", out_inst); end
        step();
        total++; if (out_count !== 3'd0) begin bad++; $display("FAIL rst_inflight got=%0d want=0", out_count); end
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        e = addi_vec(7);
        set_fields(e);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_after_valid got=%b want=1", out_valid); end
        total++; if (out_inst !== e.ei) begin bad++; $display("FAIL rst_after_inst got=%h want=%h", out_inst, e.ei); end
        total++; if (out_count !== 3'd1) begin bad++; $display("FAIL rst_after_count got=%0d want=1", out_count); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
